// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator and its channels.
// Breathe duty is a fixed 8-bit quantity so it lines up with the shared PWM counter.
package led_pattern_pkg;

  localparam int MODE_W = 2;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    dir_e              dir;
  } breathe_t;

  // One breathe step: the end points are held for one extra step while the direction flips.
  function automatic breathe_t breathe_step(input breathe_t cur);
    breathe_t nxt;
    nxt = cur;
    if (cur.dir == DIR_UP) begin
      if (cur.duty == DUTY_MAX) nxt.dir = DIR_DOWN;
      else                      nxt.duty = cur.duty + DUTY_W'(1);
    end else begin
      if (cur.duty == '0) nxt.dir = DIR_UP;
      else                nxt.duty = cur.duty - DUTY_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: holds its own mode/period and the tick count, blink and breathe state.
// The led output is combinational; the top level registers it.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PERIOD_W       = 8,
  parameter int DEFAULT_MODE   = 2,
  parameter int DEFAULT_PERIOD = 250
) (
  input  logic                clk_60mhz,
  input  logic                rst,
  input  logic                tick,
  input  logic                wr_en,
  input  logic [MODE_W-1:0]   mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   pwm_cnt,
  output logic                led
);

  localparam mode_e                RESET_MODE   = mode_e'(MODE_W'(DEFAULT_MODE));
  localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(DEFAULT_PERIOD);

  mode_e                mode_q, mode_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PERIOD_W-1:0]  count_q, count_d;
  logic                 blink_q, blink_d;
  breathe_t             breathe_q, breathe_d;
  logic [PERIOD_W-1:0]  period_last;
  logic                 step;

  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      mode_q    <= RESET_MODE;
      period_q  <= RESET_PERIOD;
      count_q   <= '0;
      blink_q   <= 1'b0;
      breathe_q <= '{duty: '0, dir: DIR_UP};
    end else begin
      mode_q    <= mode_d;
      period_q  <= period_d;
      count_q   <= count_d;
      blink_q   <= blink_d;
      breathe_q <= breathe_d;
    end
  end

  // A period of 0 behaves as 1, so the terminal count is never below zero.
  always_comb begin
    period_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    step        = (count_q == period_last);
    mode_d      = mode_q;
    period_d    = period_q;
    count_d     = count_q;
    blink_d     = blink_q;
    breathe_d   = breathe_q;
    if (wr_en) begin
      mode_d    = mode_e'(mode);
      period_d  = period;
      count_d   = '0;
      blink_d   = 1'b0;
      breathe_d = '{duty: '0, dir: DIR_UP};
    end else if (tick) begin
      if (step) begin
        count_d = '0;
        if (mode_q == MODE_BLINK)   blink_d   = ~blink_q;
        if (mode_q == MODE_BREATHE) breathe_d = breathe_step(breathe_q);
      end else begin
        count_d = count_q + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    led = 1'b0;
    unique case (mode_q)
      MODE_OFF:     led = 1'b0;
      MODE_ON:      led = 1'b1;
      MODE_BLINK:   led = blink_q;
      MODE_BREATHE: led = (pwm_cnt < breathe_q.duty);
      default:      led = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver top: prescaler, shared PWM counter, config decode and output register.
// Channels come up blinking at reset so the board shows life without a host.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS         = 6,
  parameter int TICK_DIV       = 60000,
  parameter int PERIOD_W       = 8,
  parameter int DEFAULT_MODE   = 2,
  parameter int DEFAULT_PERIOD = 250,
  localparam int CHAN_W        = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                clk_60mhz,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                cfg_err,
  output logic [N_LEDS-1:0]   led,
  output logic                tick
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [DUTY_W-1:0]  pwm_cnt;
  logic               accept;
  logic               chan_ok;
  logic [N_LEDS-1:0]  wr_en;
  logic [N_LEDS-1:0]  chan_led;

  // Prescaler and PWM counter free-run; config writes never disturb them.
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= (presc_cnt == PRESC_LAST) ? '0 : presc_cnt + PRESC_W'(1);
      tick      <= (presc_cnt == PRESC_LAST);
      pwm_cnt   <= pwm_cnt + DUTY_W'(1);
    end
  end

  // Extra bit keeps the range check correct when N_LEDS is a power of two.
  assign accept  = cfg_valid && cfg_ready;
  assign chan_ok = ({1'b0, cfg_chan} < (CHAN_W + 1)'(N_LEDS));

  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      led       <= '0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept && !chan_ok;
      led       <= chan_led;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    assign wr_en[i] = accept && chan_ok && (cfg_chan == CHAN_W'(i));

    led_channel #(
      .PERIOD_W       (PERIOD_W),
      .DEFAULT_MODE   (DEFAULT_MODE),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk_60mhz (clk_60mhz),
      .rst       (rst),
      .tick      (tick),
      .wr_en     (wr_en[i]),
      .mode      (cfg_mode),
      .period    (cfg_period),
      .pwm_cnt   (pwm_cnt),
      .led       (chan_led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen, checked cycle by cycle against a model that derives
// each LED from the number of ticks seen since the channel was last configured.
module tb_led_pattern_gen;

  localparam int N        = 6;
  localparam int TICK_DIV = 4;
  localparam int DEF_PER  = 3;

  logic       clk_60mhz = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_chan;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic       cfg_err;
  logic [N-1:0] led;
  logic       tick;

  always #5 clk_60mhz = ~clk_60mhz;

  led_pattern_gen #(
    .N_LEDS         (N),
    .TICK_DIV       (TICK_DIV),
    .PERIOD_W       (8),
    .DEFAULT_MODE   (2),
    .DEFAULT_PERIOD (DEF_PER)
  ) dut (
    .clk_60mhz  (clk_60mhz),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_err    (cfg_err),
    .led        (led),
    .tick       (tick)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: k counts clock edges since reset release.
  int         k;
  int         m_mode  [N];
  int         m_peff  [N];
  int         m_ticks [N];
  logic [N-1:0] exp_led;
  logic       exp_tick, exp_err, exp_ready;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h edge=%0d", tag, observed, expected, k);
    end
  endtask

  function automatic logic chanLed(input int ch, input int pwm);
    int   steps, s, duty;
    logic result;
    steps  = m_ticks[ch] / m_peff[ch];
    result = 1'b0;
    case (m_mode[ch])
      0: result = 1'b0;
      1: result = 1'b1;
      2: result = (steps % 2) == 1;
      default: begin
        s      = steps % 512;
        duty   = (s < 256) ? s : 511 - s;
        result = pwm < duty;
      end
    endcase
    return result;
  endfunction

  task automatic modelReset();
    k = 0;
    for (int ch = 0; ch < N; ch++) begin
      m_mode[ch]  = 2;
      m_peff[ch]  = DEF_PER;
      m_ticks[ch] = 0;
    end
    exp_led   = '0;
    exp_tick  = 1'b0;
    exp_err   = 1'b0;
    exp_ready = 1'b0;
  endtask

  task automatic modelEdge(input logic v, input int ch, input int md, input int per);
    logic [N-1:0] new_led;
    logic         accept;
    logic         tick_seen;
    k++;
    for (int c = 0; c < N; c++) new_led[c] = chanLed(c, (k - 1) % 256);
    tick_seen = exp_tick;
    accept    = v && exp_ready;
    for (int c = 0; c < N; c++) begin
      if (accept && ch == c) begin
        m_mode[c]  = md;
        m_peff[c]  = (per == 0) ? 1 : per;
        m_ticks[c] = 0;
      end else if (tick_seen) begin
        m_ticks[c]++;
      end
    end
    exp_err   = accept && (ch >= N);
    exp_tick  = (k >= TICK_DIV) && (k % TICK_DIV == 0);
    exp_ready = 1'b1;
    exp_led   = new_led;
  endtask

  task automatic applyStimulus(input logic v, input int ch, input int md, input int per);
    cfg_valid  = v;
    cfg_chan   = 3'(ch);
    cfg_mode   = 2'(md);
    cfg_period = 8'(per);
    @(posedge clk_60mhz);
    modelEdge(v, ch, md, per);
    @(negedge clk_60mhz);
    cfg_valid = 1'b0;
    checkOutput("led", 32'(led), 32'(exp_led));
    checkOutput("tick", 32'(tick), 32'(exp_tick));
    checkOutput("cfg_err", 32'(cfg_err), 32'(exp_err));
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_led"}, 32'(led), 32'(0));
    checkOutput({tag, "_ready"}, 32'(cfg_ready), 32'(0));
    checkOutput({tag, "_tick"}, 32'(tick), 32'(0));
    checkOutput({tag, "_err"}, 32'(cfg_err), 32'(0));
  endtask

  initial begin
    int per;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_chan   = '0;
    cfg_mode   = '0;
    cfg_period = '0;
    modelReset();
    @(negedge clk_60mhz);
    @(negedge clk_60mhz);
    checkResetOutputs("reset");
    #2 rst = 1'b0;

    // Write attempted while cfg_ready is still low must be ignored; then free-running blink.
    applyStimulus(1'b1, 0, 1, 5);
    idle(60);

    // Channel 2 ON then OFF.
    applyStimulus(1'b1, 2, 1, 4);
    idle(5);
    applyStimulus(1'b1, 2, 0, 4);
    idle(5);

    // Channel 1 breathes through a full up/down cycle.
    applyStimulus(1'b1, 1, 3, 1);
    idle(2100);

    // Channel 5 blink with period 0, then a write to a non-existent channel.
    applyStimulus(1'b1, 5, 2, 0);
    idle(20);
    applyStimulus(1'b1, 7, 1, 1);
    idle(10);

    // Write landing on the same edge as a tick.
    for (int i = 0; i < 2 * TICK_DIV && !exp_tick; i++) idle(1);
    applyStimulus(1'b1, 0, 2, 2);
    idle(20);

    // Random traffic, including out-of-range channels and wide periods.
    repeat (1500) begin
      if ($urandom_range(7) == 0) begin
        per = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(4));
        applyStimulus(1'b1, int'($urandom_range(7)), int'($urandom_range(3)), per);
      end else begin
        idle(1);
      end
    end

    // Asynchronous reset in the middle of a breathe sequence.
    applyStimulus(1'b1, 3, 3, 1);
    idle(300);
    #2 rst = 1'b1;
    #1 checkResetOutputs("midrst");
    modelReset();
    @(negedge clk_60mhz);
    checkResetOutputs("midrst_hold");
    #2 rst = 1'b0;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
